// File: rtl/mux32_arbiter2.sv
// Two-requester round-robin arbiter feeding a registered 2:1 operand mux.
// The selected word is held in an output register and handed downstream with a valid/ready handshake.
module mux32_arbiter2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt1,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last;
   logic             can_take;
   logic             grant;
   logic [WIDTH-1:0] mux_out;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: each combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (grant) state_next = FULL;
         FULL:    if (!grant && out_ready) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // The register can accept a word when empty, or when its current word leaves this same edge.
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      can_take = (state == EMPTY) || out_ready;
      if (rst_n && can_take) begin
         if (req0 && req1) begin
            gnt0 = last;
            gnt1 = !last;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign sel       = gnt1;
   assign grant     = gnt0 | gnt1;
   assign mux_out   = sel ? data1 : data0;
   assign out_valid = (state == FULL);

   // last starts at 1 so requester 0 wins the first contested cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data <= '0;
         out_src  <= 1'b0;
         last     <= 1'b1;
      end else if (grant) begin
         out_data <= mux_out;
         out_src  <= gnt1;
         last     <= gnt1;
      end
   end

endmodule

// File: tb/tb_mux32_arbiter2.sv
// Self-checking bench for mux32_arbiter2: directed scenarios plus randomized traffic
// compared against a transaction-level model of the output register and round-robin pointer.
module tb_mux32_arbiter2;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1, out_ready;
   logic [W-1:0] data0, data1;
   logic         gnt0, gnt1, sel, out_valid, out_src;
   logic [W-1:0] out_data;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: content of the output register and the round-robin pointer
   logic         m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   logic         m_src   = 1'b0;
   logic         m_last  = 1'b1;
   logic [1:0]   last_g  = 2'b00;

   mux32_arbiter2 #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .data1(data1), .gnt1(gnt1),
      .sel(sel), .out_valid(out_valid), .out_data(out_data),
      .out_src(out_src), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Expected {gnt1, gnt0} from the arbitration rules and the model's current contents.
   function automatic logic [1:0] exp_gnt();
      if (!rst_n) return 2'b00;
      if (m_valid && !out_ready) return 2'b00;
      if (req0 && req1) return m_last ? 2'b01 : 2'b10;
      if (req0) return 2'b01;
      if (req1) return 2'b10;
      return 2'b00;
   endfunction

   // Advance one clock: called just after a falling edge with inputs already set.
   task automatic tick();
      logic [1:0] g;
      g = exp_gnt();
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
      end else if (g != 2'b00) begin
         m_data  = g[1] ? data1 : data0;
         m_src   = g[1];
         m_last  = g[1];
         m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      last_g = g;
      @(negedge clk);
   endtask

   task automatic test_reset();
      req0 = 0; req1 = 0; data0 = '0; data1 = '0; out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         rst_n = (i >= 2);
         #1;
         if (i > 0) begin
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== '0) begin
               n_err++;
               $display("FAIL reset_out cyc %0d: valid=%b data=%h, want 0/00000000", i, out_valid, out_data);
            end
         end
         n_cmp++;
         if ({gnt1, gnt0, sel} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_gnt cyc %0d: gnt1,gnt0,sel=%b%b%b, want 000", i, gnt1, gnt0, sel);
         end
         tick();
      end
   endtask

   task automatic test_single();
      req1 = 1; data1 = 32'hDEADBEEF; out_ready = 1;
      #1;
      n_cmp++;
      if ({gnt1, sel, gnt0} !== 3'b110) begin
         n_err++;
         $display("FAIL single_gnt: gnt1,sel,gnt0=%b%b%b, want 110", gnt1, sel, gnt0);
      end
      tick();
      req1 = 0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 1'b1) begin
         n_err++;
         $display("FAIL single_out: valid=%b data=%h src=%b, want 1/deadbeef/1", out_valid, out_data, out_src);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_drain: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_contention();
      rst_n = 0; tick(); rst_n = 1;
      req0 = 1; req1 = 1; data0 = 32'h11; data1 = 32'h22; out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
            n_err++;
            $display("FAIL rr_gnt %0d: gnt0=%b gnt1=%b, want grant to %0d", i, gnt0, gnt1, i % 2);
         end
         tick();
         #1;
         n_cmp++;
         if (out_data !== ((i % 2) ? 32'h22 : 32'h11) || out_src !== 1'(i % 2) || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rr_out %0d: data=%h src=%b valid=%b, want %h/%0d/1",
                     i, out_data, out_src, out_valid, (i % 2) ? 32'h22 : 32'h11, i % 2);
         end
      end
      req0 = 0; req1 = 0;
      tick();
   endtask

   task automatic test_backpressure();
      req0 = 1; data0 = 32'hA5A5A5A5; out_ready = 0;
      tick();
      data0 = 32'h5A5A0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (gnt0 !== 1'b0 || out_data !== 32'hA5A5A5A5 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold %0d: gnt0=%b data=%h valid=%b, want 0/a5a5a5a5/1", i, gnt0, out_data, out_valid);
         end
         tick();
      end
      out_ready = 1;
      #1;
      n_cmp++;
      if (gnt0 !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: gnt0=%b, want 1", gnt0);
      end
      tick();
      req0 = 0;
      #1;
      n_cmp++;
      if (out_data !== 32'h5A5A0001 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_next: data=%h valid=%b, want 5a5a0001/1", out_data, out_valid);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      req0 = 1; data0 = 32'hCAFE0001; out_ready = 1;
      tick();
      data0 = 32'h12345678;
      #1;
      n_cmp++;
      if (gnt0 !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_gnt: gnt0=%b, want 1", gnt0);
      end
      tick();
      req0 = 0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
         n_err++;
         $display("FAIL b2b_out: valid=%b data=%h, want 1/12345678", out_valid, out_data);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      req0 = 1; data0 = 32'h0BAD0000; out_ready = 0;
      tick();
      req0 = 0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_full: valid=%b src=%b, want 1/0", out_valid, out_src);
      end
      rst_n = 0;
      tick();
      rst_n = 1;
      req0 = 1; req1 = 1; data0 = 32'h0000AAAA; data1 = 32'h0000BBBB; out_ready = 1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_after: valid=%b gnt0=%b gnt1=%b, want 0/1/0", out_valid, gnt0, gnt1);
      end
      tick();
      req0 = 0; req1 = 0;
      tick();
   endtask

   // Random traffic: requesters keep req/data until granted, then pick fresh values.
   task automatic test_random();
      logic [1:0] g;
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 59) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = exp_gnt();
         n_cmp++;
         if ({gnt1, gnt0} !== g || sel !== g[1]) begin
            n_err++;
            $display("FAIL rand_gnt %0d: gnt1,gnt0=%b%b sel=%b, want %b sel=%b", i, gnt1, gnt0, sel, g, g[1]);
         end
         n_cmp++;
         if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src) begin
            n_err++;
            $display("FAIL rand_out %0d: valid=%b data=%h src=%b, want %b/%h/%b",
                     i, out_valid, out_data, out_src, m_valid, m_data, m_src);
         end
         tick();
         if (!req0 || last_g[0]) begin req0 = $urandom_range(0, 1); data0 = $urandom; end
         if (!req1 || last_g[1]) begin req1 = $urandom_range(0, 1); data1 = $urandom; end
      end
   endtask

   initial begin
      rst_n = 0; req0 = 0; req1 = 0; data0 = '0; data1 = '0; out_ready = 0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
